// File: rtl/data_memory_hs.sv
// data_memory_hs
//   Word-addressed synchronous RAM with per-byte write strobes, a valid/ready
//   request port and a registered single-cycle response after a configurable
//   number of wait states. Requests whose address carries IO_PREFIX in bits
//   [31:28] are answered (rdata = 0, resp_io = 1) without touching the RAM.
//
// Ports
//   clk         clock, rising edge
//   reset_n     synchronous active-low reset
//   req_valid   request present
//   req_ready   block can accept a request this cycle
//   req_wr      1 = write, 0 = read
//   req_addr    byte/word address; word index = req_addr[ADDR_BIT_WIDTH-1:0]
//   req_wdata   write data
//   req_be      byte-lane write enables
//   resp_valid  one-cycle response strobe
//   resp_rdata  read data (word value before any write of the same request)
//   resp_io     response belongs to an IO-region request
//
// Handshake: a request transfers on a rising edge where reset_n, req_valid and
// req_ready are all 1. req_ready depends only on internal state, never on
// req_valid. Responses cannot be stalled: resp_valid is a one-cycle pulse, and
// resp_rdata/resp_io are meaningful only while resp_valid is 1.

module data_memory_hs #(
    parameter int         ADDR_BIT_WIDTH = 11,
    parameter int         DATA_BIT_WIDTH = 32,
    parameter int         WAIT_STATES    = 0,
    parameter logic [3:0] IO_PREFIX      = 4'hf
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_wr,
    input  logic [31:0]                 req_addr,
    input  logic [DATA_BIT_WIDTH-1:0]   req_wdata,
    input  logic [DATA_BIT_WIDTH/8-1:0] req_be,
    output logic                        resp_valid,
    output logic [DATA_BIT_WIDTH-1:0]   resp_rdata,
    output logic                        resp_io
);

    localparam int N_WORDS = 1 << ADDR_BIT_WIDTH;
    localparam int N_LANES = DATA_BIT_WIDTH / 8;

    generate
        if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
            $error("data_memory_hs: WAIT_STATES must be in 0..15");
        end
        if (DATA_BIT_WIDTH % 8 != 0) begin : g_bad_width
            $error("data_memory_hs: DATA_BIT_WIDTH must be a multiple of 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;

    logic [DATA_BIT_WIDTH-1:0] mem [N_WORDS];

    logic [ADDR_BIT_WIDTH-1:0] req_idx;
    logic                      req_is_io;
    logic                      accept;
    logic [DATA_BIT_WIDTH-1:0] rd_word;

    // Held result of the accepted request, waiting out the wait states.
    logic [DATA_BIT_WIDTH-1:0] hold_data_q;
    logic                      hold_io_q;

    // Upper index bits are ignored so the index wraps modulo N_WORDS.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[27:ADDR_BIT_WIDTH];

    assign req_idx   = req_addr[ADDR_BIT_WIDTH-1:0];
    assign req_is_io = (req_addr[31:28] == IO_PREFIX);
    assign req_ready = (state_q != BUSY);
    assign accept    = req_valid && req_ready;
    assign rd_word   = req_is_io ? '0 : mem[req_idx];

    assign resp_valid = (state_q == RESP);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d    = BUSY;
                        wait_cnt_d = 4'(WAIT_STATES - 1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM array has no reset so it maps onto block memory. The write shares the
    // accept edge with the read of rd_word, which therefore sees the old word.
    always_ff @(posedge clk) begin
        if (reset_n && accept && req_wr && !req_is_io) begin
            for (int i = 0; i < N_LANES; i++) begin
                if (req_be[i]) begin
                    mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response registers are loaded on the edge that enters RESP, so they keep
    // their last value while a later request is still waiting in BUSY.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_data_q <= '0;
            hold_io_q   <= 1'b0;
            resp_rdata  <= '0;
            resp_io     <= 1'b0;
        end else begin
            if (accept) begin
                hold_data_q <= rd_word;
                hold_io_q   <= req_is_io;
            end
            if (accept && WAIT_STATES == 0) begin
                resp_rdata <= rd_word;
                resp_io    <= req_is_io;
            end else if (state_q == BUSY && wait_cnt_q == 4'd0) begin
                resp_rdata <= hold_data_q;
                resp_io    <= hold_io_q;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_hs.sv
// tb_data_memory_hs
//   Three instances of data_memory_hs with WAIT_STATES = 0, 3 and 2, each with
//   its own request signals and reset. Only one instance is active at a time,
//   so a single in-order expected queue covers all of them. Each entry holds
//   {instance, due cycle, data_known, io, data}.

module tb_data_memory_hs;

    localparam int W = 52;

    logic        clk;
    logic        reset_n    [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_wr     [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic [3:0]  req_be     [3];
    logic        resp_valid [3];
    logic [31:0] resp_rdata [3];
    logic        resp_io    [3];

    logic [W-1:0] exp_q[$];
    logic [31:0]  ref_mem [int];

    int  cyc      = 0;
    int  n_cmp    = 0;
    int  n_bad    = 0;
    bit  chk_rdy0 = 0;

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 3 : 2;
    endfunction

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            data_memory_hs #(
                .ADDR_BIT_WIDTH(11),
                .DATA_BIT_WIDTH(32),
                .WAIT_STATES   ((g == 0) ? 0 : (g == 1) ? 3 : 2),
                .IO_PREFIX     (4'hf)
            ) u_dut (
                .clk       (clk),
                .reset_n   (reset_n[g]),
                .req_valid (req_valid[g]),
                .req_ready (req_ready[g]),
                .req_wr    (req_wr[g]),
                .req_addr  (req_addr[g]),
                .req_wdata (req_wdata[g]),
                .req_be    (req_be[g]),
                .resp_valid(resp_valid[g]),
                .resp_rdata(resp_rdata[g]),
                .resp_io   (resp_io[g])
            );
        end
    endgenerate

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model plus scoreboard push for a request accepted at the next edge.
    task automatic push_exp(input int k, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] be, input bit want);
        int          key;
        logic        io;
        logic        known;
        logic [31:0] d;
        key = k * 4096 + int'(addr[10:0]);
        io  = (addr[31:28] == 4'hf);
        if (io) begin
            d = '0; known = 1'b1;
        end else if (ref_mem.exists(key)) begin
            d = ref_mem[key]; known = 1'b1;
        end else begin
            d = '0; known = 1'b0;
        end
        if (wr && !io) begin
            if (be == 4'hf) begin
                ref_mem[key] = wd;
            end else if (ref_mem.exists(key)) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) ref_mem[key][8*i +: 8] = wd[8*i +: 8];
            end
        end
        if (want)
            exp_q.push_back({2'(k), 16'(cyc + 1 + ws_of(k)), known, io, d});
    endtask

    task automatic drive(input int k, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be);
        req_valid[k] = 1'b1;
        req_wr[k]    = wr;
        req_addr[k]  = addr;
        req_wdata[k] = wd;
        req_be[k]    = be;
    endtask

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic issue(input int k, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be);
        int guard;
        guard = 0;
        drive(k, wr, addr, wd, be);
        while (!req_ready[k] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("issue_ready_wait", 64'(req_ready[k]), 64'd1);
        push_exp(k, wr, addr, wd, be, 1'b1);
        @(negedge clk);
        req_valid[k] = 1'b0;
    endtask

    // Scoreboard: pop and compare on every response strobe
    always @(negedge clk) begin
        logic [W-1:0] e;
        for (int k = 0; k < 3; k++) begin
            if (resp_valid[k] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected_inst", 64'(k), 64'd3);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_inst", 64'(k), 64'(e[51:50]));
                    chk("resp_cycle", 64'(cyc[15:0]), 64'(e[49:34]));
                    chk("resp_io", 64'(resp_io[k]), 64'(e[32]));
                    if (e[33]) chk("resp_rdata", 64'(resp_rdata[k]), 64'(e[31:0]));
                end
            end
        end
        if (exp_q.size() > 0 && exp_q[0][49:34] < cyc[15:0]) begin
            e = exp_q.pop_front();
            chk("resp_missing_due", 64'(cyc[15:0]), 64'(e[49:34]));
        end
        if (chk_rdy0) chk("ready_ws0", 64'(req_ready[0]), 64'd1);
    end

    initial begin
        logic [31:0] a, d;
        logic [3:0]  b;
        logic        w;

        for (int k = 0; k < 3; k++) begin
            reset_n[k] = 1'b0;
            req_valid[k] = 1'b0; req_wr[k] = 1'b0;
            req_addr[k] = '0; req_wdata[k] = '0; req_be[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) reset_n[k] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_ready", 64'(req_ready[k]), 64'd1);
            chk("reset_resp_valid", 64'(resp_valid[k]), 64'd0);
            chk("reset_rdata", 64'(resp_rdata[k]), 64'd0);
            chk("reset_io", 64'(resp_io[k]), 64'd0);
        end
        chk_rdy0 = 1'b1;

        // WAIT_STATES=0: back-to-back write then read of word 5
        issue(0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 4'hf);
        issue(0, 1'b0, 32'h0000_0005, 32'h0, 4'h0);
        repeat (2) @(negedge clk);

        // Byte lanes, read-before-write, no-op write
        issue(0, 1'b1, 32'h0000_0009, 32'h1122_3344, 4'hf);
        issue(0, 1'b1, 32'h0000_0009, 32'hAABB_CCDD, 4'b0101);
        issue(0, 1'b0, 32'h0000_0009, 32'h0, 4'h0);
        issue(0, 1'b1, 32'h0000_0009, 32'hFFFF_FFFF, 4'h0);
        issue(0, 1'b0, 32'h0000_0009, 32'h0, 4'h0);

        // IO region leaves RAM untouched
        issue(0, 1'b1, 32'hF000_0005, 32'h1234_5678, 4'hf);
        issue(0, 1'b0, 32'h0000_0005, 32'h0, 4'h0);

        // Index wrap-around
        issue(0, 1'b1, 32'h0000_0803, 32'h0000_0055, 4'hf);
        issue(0, 1'b0, 32'h0000_0003, 32'h0, 4'h0);

        // Random mix on a small address window
        for (int i = 0; i < 24; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) a[31:28] = 4'hf;
            d = $urandom;
            b = 4'($urandom_range(0, 15));
            issue(0, w, a, d, b);
        end
        repeat (3) @(negedge clk);
        chk_rdy0 = 1'b0;

        // WAIT_STATES=3: busy window and a request held through it
        issue(1, 1'b1, 32'h0000_0002, 32'hCAFE_F00D, 4'hf);
        repeat (4) @(negedge clk);
        issue(1, 1'b0, 32'h0000_0002, 32'h0, 4'h0);
        drive(1, 1'b0, 32'h0000_0002, 32'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            chk("ws3_busy_ready", 64'(req_ready[1]), 64'd0);
            @(negedge clk);
        end
        chk("ws3_ready_again", 64'(req_ready[1]), 64'd1);
        push_exp(1, 1'b0, 32'h0000_0002, 32'h0, 4'h0, 1'b1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        repeat (5) @(negedge clk);

        // WAIT_STATES=2: reset one cycle after a write accept
        issue(2, 1'b1, 32'h0000_0015, 32'h0102_0304, 4'hf);
        repeat (3) @(negedge clk);
        drive(2, 1'b1, 32'h0000_001E, 32'hA5A5_A5A5, 4'hf);
        push_exp(2, 1'b1, 32'h0000_001E, 32'hA5A5_A5A5, 4'hf, 1'b0);
        @(negedge clk);
        reset_n[2] = 1'b0;
        drive(2, 1'b1, 32'h0000_0015, 32'hFFFF_FFFF, 4'hf);
        @(negedge clk);
        reset_n[2] = 1'b1;
        req_valid[2] = 1'b0;
        chk("rst_resp_valid", 64'(resp_valid[2]), 64'd0);
        chk("rst_rdata", 64'(resp_rdata[2]), 64'd0);
        chk("rst_io", 64'(resp_io[2]), 64'd0);
        chk("rst_ready", 64'(req_ready[2]), 64'd1);
        repeat (5) @(negedge clk);
        issue(2, 1'b0, 32'h0000_001E, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        issue(2, 1'b0, 32'h0000_0015, 32'h0, 4'h0);
        repeat (5) @(negedge clk);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
